// File: rtl/vend_payment_controller_if.sv
// ---------------------------------------------------------------------------
// vend_payment_controller_if
//
// Bundles every front-end and actuator signal of the vending payment
// controller.
//   master : keypad / coin acceptor / dispenser / hopper side
//            (drives requests and acks, observes status)
//   slave  : the payment controller itself
//
// Front end -> controller
//   select_valid, select_price[5:0] : product selection strobe and price
//   coin_valid, coin_value[4:0]     : coin insertion strobe and value
//   cancel                          : user cancel, level-sampled
//   dispense_ack                    : dispenser has released the product
//   change_ack                      : hopper has ejected one 10-euro coin
// Controller -> front end / actuators
//   busy, credit[5:0], coin_reject, dispense_req, change_req, done, vended
// ---------------------------------------------------------------------------
interface vend_payment_controller_if;
    logic       select_valid;
    logic [5:0] select_price;
    logic       coin_valid;
    logic [4:0] coin_value;
    logic       cancel;
    logic       dispense_ack;
    logic       change_ack;

    logic       busy;
    logic [5:0] credit;
    logic       coin_reject;
    logic       dispense_req;
    logic       change_req;
    logic       done;
    logic       vended;

    modport master (
        output select_valid, select_price, coin_valid, coin_value, cancel,
               dispense_ack, change_ack,
        input  busy, credit, coin_reject, dispense_req, change_req, done, vended
    );

    modport slave (
        input  select_valid, select_price, coin_valid, coin_value, cancel,
               dispense_ack, change_ack,
        output busy, credit, coin_reject, dispense_req, change_req, done, vended
    );
endinterface

// File: rtl/vend_payment_controller.sv
// ---------------------------------------------------------------------------
// vend_payment_controller
//
// Runs one vending transaction at a time: latches a product price, collects
// 10/20-euro coins, requests the dispenser once the price is covered, then
// pays out change (or a full refund after cancel/timeout) in 10-euro steps.
//
// Parameters
//   MAX_CREDIT     : highest credit held, euros (<= 63, multiple of 10)
//   TIMEOUT_CYCLES : idle cycles in COLLECT before automatic refund (>= 2)
//
// Ports
//   clock : rising-edge clock
//   reset : synchronous, active-high
//   bus   : vend_payment_controller_if.slave (see interface header)
//
// All outputs are registers or pure decodes of the state register, so every
// input shows up at the outputs exactly one rising edge after it is sampled.
// ---------------------------------------------------------------------------
module vend_payment_controller #(
    parameter int MAX_CREDIT     = 60,
    parameter int TIMEOUT_CYCLES = 1000
) (
    input  logic                      clock,
    input  logic                      reset,
    vend_payment_controller_if.slave  bus
);

    localparam int             TIMER_W      = $clog2(TIMEOUT_CYCLES);
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT_CYCLES - 1);
    localparam logic [6:0]     CREDIT_LIMIT = 7'(MAX_CREDIT);

    typedef enum logic [2:0] {
        S_IDLE,
        S_COLLECT,
        S_DISPENSE,
        S_CHANGE,
        S_DONE
    } state_t;

    state_t             state, state_next;
    logic [5:0]         credit_q, credit_next;
    logic [5:0]         price_q, price_next;
    logic [TIMER_W-1:0] timer_q, timer_next;
    logic               vended_q, vended_next;
    logic               reject_q, reject_next;

    logic               price_ok;
    logic               coin_ok;
    logic               give_up;
    logic [6:0]         coin_sum;
    logic [5:0]         remainder;

    // One extra bit on the sum so a coin pushing credit past 63 cannot wrap
    // around and slip under the limit.
    assign coin_sum  = {1'b0, credit_q} + {2'b00, bus.coin_value};
    assign remainder = credit_q - price_q;

    assign price_ok = (bus.select_price != 6'd0)
                   && ((bus.select_price % 6'd10) == 6'd0)
                   && ({1'b0, bus.select_price} <= CREDIT_LIMIT);

    assign coin_ok  = ((bus.coin_value == 5'd10) || (bus.coin_value == 5'd20))
                   && (coin_sum <= CREDIT_LIMIT);

    // Cancel and timeout both end collection; either one outranks a coin.
    assign give_up  = bus.cancel || (timer_q == TIMER_LAST);

    // State and datapath registers.
    // NOTE: sequential state uses non-blocking (<=) so every register samples
    // the pre-edge values of its neighbours, independent of statement order.
    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= S_IDLE;
            credit_q <= '0;
            price_q  <= '0;
            timer_q  <= '0;
            vended_q <= 1'b0;
            reject_q <= 1'b0;
        end else begin
            state    <= state_next;
            credit_q <= credit_next;
            price_q  <= price_next;
            timer_q  <= timer_next;
            vended_q <= vended_next;
            reject_q <= reject_next;
        end
    end

    // Next-state and datapath decisions.
    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path
        // through the case leaves one unassigned and infers a latch.
        state_next  = state;
        credit_next = credit_q;
        price_next  = price_q;
        timer_next  = '0;              // counter only runs while collecting
        vended_next = vended_q;
        reject_next = bus.coin_valid;  // any coin not explicitly taken goes back

        unique case (state)
            S_IDLE: begin
                if (bus.select_valid && price_ok) begin
                    price_next = bus.select_price;
                    state_next = S_COLLECT;
                end
            end

            S_COLLECT: begin
                if (give_up) begin
                    state_next = (credit_q == 6'd0) ? S_DONE : S_CHANGE;
                end else if (bus.coin_valid && coin_ok) begin
                    reject_next = 1'b0;
                    credit_next = coin_sum[5:0];
                    if (coin_sum[5:0] >= price_q) begin
                        state_next = S_DISPENSE;
                    end
                end else begin
                    timer_next = timer_q + TIMER_W'(1);
                end
            end

            S_DISPENSE: begin
                if (bus.dispense_ack) begin
                    credit_next = remainder;
                    vended_next = 1'b1;
                    state_next  = (remainder != 6'd0) ? S_CHANGE : S_DONE;
                end
            end

            S_CHANGE: begin
                if (bus.change_ack) begin
                    credit_next = credit_q - 6'd10;
                    if (credit_q == 6'd10) begin
                        state_next = S_DONE;
                    end
                end
            end

            S_DONE: begin
                state_next  = S_IDLE;
                vended_next = 1'b0;
            end

            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // Moore outputs.
    assign bus.busy         = (state != S_IDLE);
    assign bus.credit       = credit_q;
    assign bus.coin_reject  = reject_q;
    assign bus.dispense_req = (state == S_DISPENSE);
    assign bus.change_req   = (state == S_CHANGE);
    assign bus.done         = (state == S_DONE);
    assign bus.vended       = (state == S_DONE) && vended_q;

endmodule

// File: tb/tb_vend_payment_controller.sv
// ---------------------------------------------------------------------------
// tb_vend_payment_controller
//
// Two controllers (MAX_CREDIT 60 and 40, both with an 8-cycle timeout) share
// one stimulus stream. A transaction-level reference model per instance
// predicts the output picture after every clock edge; whenever the predicted
// picture changes (or carries a pulse) it is queued with the cycle at which
// it must appear. Per-instance monitors compare the DUT against the queue.
// ---------------------------------------------------------------------------
module tb_vend_payment_controller;

    localparam int TMO   = 8;
    localparam int MAX_A = 60;
    localparam int MAX_B = 40;

    typedef struct packed {
        logic       busy;
        logic [5:0] credit;
        logic       coin_reject;
        logic       dispense_req;
        logic       change_req;
        logic       done;
        logic       vended;
    } snap_t;

    typedef struct {
        int    cyc;
        snap_t s;
    } exp_t;

    typedef enum {P_IDLE, P_PAY, P_VEND, P_REFUND, P_CLOSE} phase_e;

    typedef struct {
        phase_e ph;
        int     credit;
        int     price;
        int     waited;
        bit     vflag;
        bit     reject;
    } mstate_t;

    logic clock;
    logic reset;
    int   cyc_cnt = 0;

    logic       drv_sel_v;
    logic [5:0] drv_sel_p;
    logic       drv_coin_v;
    logic [4:0] drv_coin;
    logic       drv_cancel;
    logic       drv_dack;
    logic       drv_cack;

    int   total = 0;
    int   bad   = 0;
    bit   mon_en = 0;

    exp_t    exp_q[2][$];
    mstate_t m[2];
    snap_t   mprev[2];
    int      coin_tab[6] = '{5, 10, 20, 25, 10, 20};

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) cyc_cnt <= cyc_cnt + 1;

    function automatic string fmt(snap_t s);
        return $sformatf("busy=%0b credit=%0d rej=%0b dreq=%0b creq=%0b done=%0b vended=%0b",
                         s.busy, s.credit, s.coin_reject, s.dispense_req,
                         s.change_req, s.done, s.vended);
    endfunction

    // -----------------------------------------------------------------------
    // DUT instances and monitors
    // -----------------------------------------------------------------------
    for (genvar g = 0; g < 2; g++) begin : g_dut
        vend_payment_controller_if bus ();

        assign bus.select_valid = drv_sel_v;
        assign bus.select_price = drv_sel_p;
        assign bus.coin_valid   = drv_coin_v;
        assign bus.coin_value   = drv_coin;
        assign bus.cancel       = drv_cancel;
        assign bus.dispense_ack = drv_dack;
        assign bus.change_ack   = drv_cack;

        vend_payment_controller #(
            .MAX_CREDIT     (g == 0 ? MAX_A : MAX_B),
            .TIMEOUT_CYCLES (TMO)
        ) dut (
            .clock (clock),
            .reset (reset),
            .bus   (bus)
        );

        snap_t prev;
        snap_t cur;
        exp_t  e;
        bit    started = 0;

        always @(negedge clock) begin
            if (mon_en) begin
                cur.busy         = bus.busy;
                cur.credit       = bus.credit;
                cur.coin_reject  = bus.coin_reject;
                cur.dispense_req = bus.dispense_req;
                cur.change_req   = bus.change_req;
                cur.done         = bus.done;
                cur.vended       = bus.vended;
                if (!started) begin
                    started = 1;
                    total++;
                    if (cur !== snap_t'(0)) begin
                        bad++;
                        $display("FAIL reset_state dut%0d got {%s} want all zero", g, fmt(cur));
                    end
                end else begin
                    while (exp_q[g].size() > 0 && exp_q[g][0].cyc < cyc_cnt) begin
                        e = exp_q[g].pop_front();
                        total++;
                        bad++;
                        $display("FAIL missed_event dut%0d cyc=%0d got nothing want {%s}",
                                 g, e.cyc, fmt(e.s));
                    end
                    if (exp_q[g].size() > 0 && exp_q[g][0].cyc == cyc_cnt) begin
                        e = exp_q[g].pop_front();
                        total++;
                        if (cur !== e.s) begin
                            bad++;
                            $display("FAIL outputs dut%0d cyc=%0d got {%s} want {%s}",
                                     g, cyc_cnt, fmt(cur), fmt(e.s));
                        end
                    end else if (cur !== prev || cur.coin_reject || cur.done) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_event dut%0d cyc=%0d got {%s} want {%s}",
                                 g, cyc_cnt, fmt(cur), fmt(prev));
                    end
                end
                prev = cur;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Reference model: transaction rules in plain integer arithmetic
    // -----------------------------------------------------------------------
    function automatic mstate_t model_next(mstate_t s, int maxc, bit sv, int sp,
                                           bit cv, int cval, bit cn, bit da,
                                           bit ca, bit rs);
        mstate_t n = s;
        if (rs) begin
            n = '{ph: P_IDLE, credit: 0, price: 0, waited: 0, vflag: 0, reject: 0};
            return n;
        end
        n.reject = cv;
        case (s.ph)
            P_IDLE: begin
                if (sv && sp != 0 && sp % 10 == 0 && sp <= maxc) begin
                    n.ph     = P_PAY;
                    n.price  = sp;
                    n.waited = 0;
                end
            end
            P_PAY: begin
                if (cn || s.waited == TMO - 1) begin
                    n.ph     = (s.credit == 0) ? P_CLOSE : P_REFUND;
                    n.waited = 0;
                end else if (cv && (cval == 10 || cval == 20) && s.credit + cval <= maxc) begin
                    n.reject = 0;
                    n.credit = s.credit + cval;
                    n.waited = 0;
                    if (n.credit >= s.price) n.ph = P_VEND;
                end else begin
                    n.waited = s.waited + 1;
                end
            end
            P_VEND: begin
                if (da) begin
                    n.credit = s.credit - s.price;
                    n.vflag  = 1;
                    n.ph     = (n.credit > 0) ? P_REFUND : P_CLOSE;
                end
            end
            P_REFUND: begin
                if (ca) begin
                    n.credit = s.credit - 10;
                    if (n.credit == 0) n.ph = P_CLOSE;
                end
            end
            P_CLOSE: begin
                n.ph    = P_IDLE;
                n.vflag = 0;
            end
            default: n.ph = P_IDLE;
        endcase
        return n;
    endfunction

    function automatic snap_t model_view(mstate_t s);
        snap_t v;
        v.busy         = (s.ph != P_IDLE);
        v.credit       = 6'(s.credit);
        v.coin_reject  = s.reject;
        v.dispense_req = (s.ph == P_VEND);
        v.change_req   = (s.ph == P_REFUND);
        v.done         = (s.ph == P_CLOSE);
        v.vended       = (s.ph == P_CLOSE) && s.vflag;
        return v;
    endfunction

    // -----------------------------------------------------------------------
    // Stimulus: one call = one clock cycle of inputs
    // -----------------------------------------------------------------------
    task automatic tick(input bit sv = 0, input int sp = 0, input bit cv = 0,
                        input int cval = 0, input bit cn = 0, input bit da = 0,
                        input bit ca = 0, input bit rs = 0);
        snap_t v;
        exp_t  e;
        drv_sel_v  = sv;
        drv_sel_p  = 6'(sp);
        drv_coin_v = cv;
        drv_coin   = 5'(cval);
        drv_cancel = cn;
        drv_dack   = da;
        drv_cack   = ca;
        reset      = rs;
        for (int g = 0; g < 2; g++) begin
            m[g] = model_next(m[g], (g == 0) ? MAX_A : MAX_B, sv, sp, cv, cval, cn, da, ca, rs);
            v = model_view(m[g]);
            if (v != mprev[g] || v.coin_reject || v.done) begin
                e.cyc = cyc_cnt + 1;
                e.s   = v;
                exp_q[g].push_back(e);
            end
            mprev[g] = v;
        end
        @(negedge clock);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        reset = 1'b1;
        drv_sel_v = 0; drv_sel_p = 0; drv_coin_v = 0; drv_coin = 0;
        drv_cancel = 0; drv_dack = 0; drv_cack = 0;
        for (int g = 0; g < 2; g++) begin
            m[g] = model_next(m[g], MAX_A, 0, 0, 0, 0, 0, 0, 0, 1);
            mprev[g] = snap_t'(0);
        end
        repeat (3) @(negedge clock);
        #1;
        mon_en = 1;
        tick(.rs(1));

        // 1: exact payment, no change
        tick(.sv(1), .sp(30));
        tick(.cv(1), .cval(10));
        tick(.cv(1), .cval(20));
        idle(1);
        tick(.da(1));
        idle(2);

        // 2: overpayment, one change coin
        tick(.sv(1), .sp(30));
        tick(.cv(1), .cval(20));
        tick(.cv(1), .cval(20));
        idle(1);
        tick(.da(1));
        idle(1);
        tick(.ca(1));
        idle(2);

        // 3: cancel with a simultaneous coin
        tick(.sv(1), .sp(50));
        tick(.cv(1), .cval(10));
        tick(.cn(1), .cv(1), .cval(20));
        idle(1);
        tick(.ca(1));
        idle(2);

        // 4: timeout refund
        tick(.sv(1), .sp(30));
        tick(.cv(1), .cval(20));
        idle(10);
        tick(.ca(1));
        idle(1);
        tick(.ca(1));
        idle(2);

        // 5: rejection rules and credit ceiling
        tick(.cv(1), .cval(10));
        tick(.sv(1), .sp(40));
        tick(.cv(1), .cval(15));
        tick(.cv(1), .cval(20));
        tick(.cv(1), .cval(10));
        tick(.cv(1), .cval(20));
        tick(.cn(1));
        tick(.da(1));
        for (int i = 0; i < 3; i++) begin
            tick(.ca(1));
            idle(1);
        end
        tick(.sv(1), .sp(60));
        idle(1);
        tick(.cn(1));
        idle(2);

        // 6: reset while refunding
        tick(.sv(1), .sp(30));
        tick(.cv(1), .cval(20));
        tick(.cn(1));
        tick(.rs(1));
        tick(.ca(1));
        idle(2);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            tick(.sv($urandom_range(0, 7) == 0),
                 .sp($urandom_range(0, 1) ? 10 * int'($urandom_range(0, 6))
                                          : int'($urandom_range(0, 63))),
                 .cv($urandom_range(0, 3) == 0),
                 .cval(coin_tab[$urandom_range(0, 5)]),
                 .cn($urandom_range(0, 39) == 0),
                 .da($urandom_range(0, 2) == 0),
                 .ca($urandom_range(0, 2) == 0),
                 .rs($urandom_range(0, 499) == 0));
        end

        idle(4);
        repeat (2) @(negedge clock);
        #1;
        for (int g = 0; g < 2; g++) begin
            total++;
            if (exp_q[g].size() != 0) begin
                bad++;
                $display("FAIL drain dut%0d got %0d unobserved events want 0", g, exp_q[g].size());
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
